// File: rtl/irq_pending_ctrl.sv
// Captures three asynchronous request lines, keeps them pending until serviced,
// and offers them one at a time to a consumer through a valid/ack handshake.
module irq_pending_ctrl #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_in,
  input  logic [2:0] mask,
  output logic [2:0] pend_vec,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] hist_q;
  logic [2:0] rise;
  logic [2:0] clr;
  logic [2:0] pending_q;
  logic [2:0] pending_d;
  logic [2:0] pend_vec_q;
  state_e     state_q;
  logic       irq_valid_q;
  logic [1:0] irq_id_q;
  logic       busy_q;

  function automatic logic [1:0] encode(input logic [2:0] v);
    logic [1:0] id;
    id = 2'b11;
    if (v[2])      id = 2'b10;
    else if (v[1]) id = 2'b01;
    else if (v[0]) id = 2'b00;
    return id;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Clear only the bit being acknowledged; a coincident rise still wins below.
  always_comb begin
    clr = '0;
    if (state_q == OFFER && irq_ack) begin
      clr = 3'b001 << irq_id_q;
    end
  end

  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_vec_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_vec_q <= pending_q & ~mask;
    end
  end

  // irq_id is latched on entry to OFFER and held until the next offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 2'b11;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pend_vec_q) begin
            irq_id_q    <= encode(pend_vec_q);
            irq_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            irq_valid_q <= 1'b0;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          irq_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign pend_vec  = pend_vec_q;
  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed checks of irq_pending_ctrl with SYNC_STAGES=2, expected values worked out by hand.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] req_in;
  logic [2:0] mask;
  logic [2:0] pend_vec;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic       busy;

  int total;
  int bad;

  irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .pend_vec  (pend_vec),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset holds everything idle; release with all lines high gives three back-to-back offers.
  task automatic test_reset;
    rst_n = 1'b0; req_in = 3'b111; mask = 3'b000; irq_ack = 1'b0;
    tick(3);
    total++; if (pend_vec !== 3'b000) begin bad++; $display("FAIL rst_pend_vec got=%b exp=000", pend_vec); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL rst_irq_valid got=%b exp=0", irq_valid); end
    total++; if (irq_id !== 2'b11) begin bad++; $display("FAIL rst_irq_id got=%b exp=11", irq_id); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick(3);  // after edge k+2: pending just set, pend_vec not yet
    total++; if (pend_vec !== 3'b000) begin bad++; $display("FAIL rel_pend_early got=%b exp=000", pend_vec); end
    tick(1);  // k+3
    total++; if (pend_vec !== 3'b111) begin bad++; $display("FAIL rel_pend_vec got=%b exp=111", pend_vec); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL rel_valid_early got=%b exp=0", irq_valid); end
    tick(1);  // k+4
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL b2b_offer0 got=%b/%b exp=1/10", irq_valid, irq_id); end
    irq_ack = 1'b1;
    tick(1);  // k+5
    total++; if (irq_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_settle got=%b/%b exp=0/1", irq_valid, busy); end
    tick(1);  // k+6
    total++; if (busy !== 1'b0 || pend_vec !== 3'b011) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=0/011", busy, pend_vec); end
    tick(1);  // k+7
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b01) begin bad++; $display("FAIL b2b_offer1 got=%b/%b exp=1/01", irq_valid, irq_id); end
    tick(3);  // k+10
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin bad++; $display("FAIL b2b_offer2 got=%b/%b exp=1/00", irq_valid, irq_id); end
    tick(2);  // k+12
    total++; if (pend_vec !== 3'b000 || busy !== 1'b0 || irq_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b/%b/%b exp=000/0/0", pend_vec, busy, irq_valid); end
    irq_ack = 1'b0; req_in = 3'b000;
    tick(5);
  endtask

  task automatic test_single;
    req_in = 3'b010;
    tick(3);  // k+2
    total++; if (pend_vec !== 3'b000) begin bad++; $display("FAIL single_pend_early got=%b exp=000", pend_vec); end
    tick(1);  // k+3
    total++; if (pend_vec !== 3'b010 || irq_valid !== 1'b0) begin bad++; $display("FAIL single_pend got=%b/%b exp=010/0", pend_vec, irq_valid); end
    tick(1);  // k+4
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL single_offer got=%b/%b/%b exp=1/01/1", irq_valid, irq_id, busy); end
    tick(1);  // k+5, no ack yet: offer held
    total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL single_hold got=%b exp=1", irq_valid); end
    irq_ack = 1'b1;
    tick(1);  // k+6
    irq_ack = 1'b0;
    total++; if (irq_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_ack got=%b/%b exp=0/1", irq_valid, busy); end
    tick(1);  // k+7
    total++; if (pend_vec !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b exp=000/0", pend_vec, busy); end
    req_in = 3'b000;
    tick(4);
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_level_once got=%b exp=0", irq_valid); end
  endtask

  task automatic test_priority;
    irq_ack = 1'b1;  // ack held while idle must be ignored
    tick(2);
    irq_ack = 1'b0;
    req_in = 3'b101;
    tick(5);  // k+4
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL prio_first got=%b/%b exp=1/10", irq_valid, irq_id); end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tick(2);
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin bad++; $display("FAIL prio_second got=%b/%b exp=1/00", irq_valid, irq_id); end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tick(1);
    total++; if (pend_vec !== 3'b000 || busy !== 1'b0) begin bad++; $display("FAIL prio_done got=%b/%b exp=000/0", pend_vec, busy); end
    req_in = 3'b000;
    tick(4);
  endtask

  task automatic test_mask;
    mask = 3'b100;
    req_in = 3'b101;
    tick(4);  // k+3
    total++; if (pend_vec !== 3'b001) begin bad++; $display("FAIL mask_pend got=%b exp=001", pend_vec); end
    tick(1);
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin bad++; $display("FAIL mask_offer got=%b/%b exp=1/00", irq_valid, irq_id); end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    mask = 3'b000;
    tick(1);
    total++; if (pend_vec !== 3'b100) begin bad++; $display("FAIL mask_release got=%b exp=100", pend_vec); end
    tick(1);
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL mask_unmasked got=%b/%b exp=1/10", irq_valid, irq_id); end
    mask = 3'b100;  // masking the offered bit does not withdraw it
    tick(2);
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10 || pend_vec !== 3'b000) begin bad++; $display("FAIL mask_during_offer got=%b/%b/%b exp=1/10/000", irq_valid, irq_id, pend_vec); end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    mask = 3'b000;
    tick(3);
    total++; if (pend_vec !== 3'b000 || irq_valid !== 1'b0) begin bad++; $display("FAIL mask_ack_clears got=%b/%b exp=000/0", pend_vec, irq_valid); end
    req_in = 3'b000;
    tick(4);
  endtask

  // Second edge on bit 0 timed so its rise lands on the same edge as the ack clear.
  task automatic test_collision;
    req_in = 3'b001;
    tick(1);  // k0
    req_in = 3'b000;
    tick(3);  // k0+3
    req_in = 3'b001;
    tick(1);  // k0+4
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin bad++; $display("FAIL coll_offer got=%b/%b exp=1/00", irq_valid, irq_id); end
    tick(1);  // k0+5
    irq_ack = 1'b1;
    tick(1);  // k0+6: clr[0] and rise[0] together
    irq_ack = 1'b0;
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL coll_ack got=%b exp=0", irq_valid); end
    tick(1);  // k0+7
    total++; if (pend_vec !== 3'b001) begin bad++; $display("FAIL coll_kept got=%b exp=001", pend_vec); end
    tick(1);  // k0+8
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin bad++; $display("FAIL coll_reoffer got=%b/%b exp=1/00", irq_valid, irq_id); end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    req_in = 3'b000;
    tick(4);
    total++; if (pend_vec !== 3'b000 || irq_valid !== 1'b0) begin bad++; $display("FAIL coll_drain got=%b/%b exp=000/0", pend_vec, irq_valid); end
  endtask

  task automatic test_reset_mid_offer;
    req_in = 3'b110;
    tick(5);
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL rmo_offer got=%b/%b exp=1/10", irq_valid, irq_id); end
    #2;
    rst_n = 1'b0;
    req_in = 3'b000;
    #1;
    total++; if (irq_valid !== 1'b0 || busy !== 1'b0 || pend_vec !== 3'b000 || irq_id !== 2'b11) begin bad++; $display("FAIL rmo_async got=%b/%b/%b/%b exp=0/0/000/11", irq_valid, busy, pend_vec, irq_id); end
    tick(2);
    rst_n = 1'b1;
    tick(8);
    total++; if (irq_valid !== 1'b0 || pend_vec !== 3'b000) begin bad++; $display("FAIL rmo_lost got=%b/%b exp=0/000", irq_valid, pend_vec); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Request-capture and service-handshake stage that sits directly upstream of the 3-input priority encoder.
- Synchronises three asynchronous request lines, edge-detects them and holds them in a pending register.
- Applies a mask and presents the masked pending vector to the encoder (pend_vec), then issues one serviced request at a time to a consumer.
- Uses a valid/ack handshake and clears each pending bit once the consumer acknowledges it.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per request line; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_in  input  3  asynchronous request lines; a rising edge creates a request.
- mask  input  3  synchronous mask; 1 blocks the bit from presentation but does not clear pending.
- pend_vec  output  3  registered pending & ~mask; drives the priority encoder input.
- irq_valid  output  1  a request is being offered to the consumer.
- irq_id  output  2  encoded index of the offered request.
- irq_ack  input  1  consumer accepts the offered request.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all synchroniser flops, edge-history flop, pending, pend_vec, irq_valid, irq_id=2'b11, busy and FSM=IDLE clear to zero or idle immediately on rst_n low. Release is synchronous to the next clk edge.
- Sync and edge detect:
  - Per bit: SYNC_STAGES-flop chain plus one history flop.
  - rise = sync_last & ~history.
  - A level high sampled at edge k sets pending at edge k+SYNC_STAGES.
  - A level held high produces exactly one request. It must go low for at least SYNC_STAGES+1 cycles to re-arm.
- Pending register: pending[b] <= (pending[b] & ~clr[b]) | rise[b].
  - Set has priority over clear on the same cycle, so a new edge is never lost.
- pend_vec is registered from pending & ~mask, giving one cycle latency after pending or mask changes.
- Encoding, applied internally to pend_vec:
  - bit2 -> 2'b10
  - else bit1 -> 2'b01
  - else bit0 -> 2'b00
  - none -> 2'b11, which is never offered.
- FSM states:
  - IDLE: when pend_vec != 0, latch the encoded id into irq_id, set irq_valid and go to OFFER.
  - OFFER: irq_valid=1 and irq_id held stable regardless of later edges or mask changes. On irq_ack, assert clr for bit irq_id for one cycle, drop irq_valid next edge and go to SETTLE.
  - SETTLE: one cycle so pend_vec reflects the clear, then go to IDLE. irq_valid=0.
- irq_ack while not in OFFER is ignored.
- Throughput: at most one request serviced per 3 cycles (IDLE, OFFER with same-cycle ack, SETTLE).
- Back-to-back: the next highest pending bit is offered on the edge after returning to IDLE.
- A higher-priority edge arriving during OFFER does not pre-empt. It is offered after SETTLE.
- Mask asserted on the offered bit during OFFER does not withdraw the offer. The ack still clears that bit.
- rst_n low mid-OFFER: irq_valid drops asynchronously and all pending bits are lost.

Test Plan:
- Reset: hold rst_n=0 with req_in=3'b111 -> pend_vec=0, irq_valid=0, irq_id=2'b11, busy=0. After release with req_in held high, pending=3'b111 at edge SYNC_STAGES (one edge each).
- Single request: req_in[1] rises, sampled at edge k -> pending[1] at k+2, pend_vec=3'b010 at k+3, irq_valid=1 and irq_id=2'b01 at k+4. Ack at k+5 -> pending=0 and irq_valid=0 at k+6, back in IDLE at k+7.
- Priority: req_in=3'b101 simultaneously -> first offer irq_id=2'b10, ack -> second offer irq_id=2'b00, ack -> idle with pend_vec=0.
- Mask: mask=3'b100, req_in[2] and req_in[0] rise -> offer irq_id=2'b00 only. Clear mask after ack -> offer irq_id=2'b10.
- Set-vs-clear collision: during OFFER of bit 0, time a fresh req_in[0] edge so rise[0] coincides with clr[0] -> pending[0] stays 1 and bit 0 is offered again after SETTLE.
- Reset mid-operation: drop rst_n during OFFER -> irq_valid=0 asynchronously and pending=0. With no new edges after release, irq_valid stays 0.
